// File: rtl/uart_module_led.sv
// uart_module_led: Avalon-MM slave driving an 8-bit LED port.
// A static pattern (data_reg) is XORed with a blink mask. The blink phase
// toggles once every `period` clock cycles. Writing period = 0 stops blinking.
module uart_module_led (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  out_port
);

    logic [7:0]  data_q,     data_d;
    logic [7:0]  mask_q,     mask_d;
    logic [23:0] period_q,   period_d;
    logic [23:0] cnt_q,      cnt_d;
    logic        phase_q,    phase_d;
    logic [31:0] readdata_q, readdata_d;
    logic        wr;

    // No register uses writedata[31:24].
    logic        unused_wdata_hi;
    assign unused_wdata_hi = ^writedata[31:24];

    assign wr = chipselect & ~write_n;

    // Next-state logic: register writes, blink counter, and the read mux
    always_comb begin
        data_d     = data_q;
        mask_d     = mask_q;
        period_d   = period_q;
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        readdata_d = 32'd0;

        if (wr) begin
            case (address)
                3'd0:    data_d   = writedata[7:0];
                3'd1:    mask_d   = writedata[7:0];
                3'd2:    period_d = writedata[23:0];
                3'd4:    data_d   = data_q | writedata[7:0];
                3'd5:    data_d   = data_q & ~writedata[7:0];
                default: ;
            endcase
        end

        // A period write restarts the blink from a known point. This also
        // keeps cnt from ever being left above the new period-1.
        if (wr && (address == 3'd2)) begin
            cnt_d   = 24'd0;
            phase_d = 1'b0;
        end else if (period_q == 24'd0) begin
            cnt_d   = 24'd0;
            phase_d = 1'b0;
        end else if (cnt_q == (period_q - 24'd1)) begin
            cnt_d   = 24'd0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + 24'd1;
        end

        // The read mux decodes address whether or not chipselect is high.
        case (address)
            3'd0:    readdata_d = {24'd0, data_q};
            3'd1:    readdata_d = {24'd0, mask_q};
            3'd2:    readdata_d = {8'd0, period_q};
            3'd3:    readdata_d = {31'd0, phase_q};
            default: readdata_d = 32'd0;
        endcase
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= 8'd0;
            mask_q     <= 8'd0;
            period_q   <= 24'd0;
            cnt_q      <= 24'd0;
            phase_q    <= 1'b0;
            readdata_q <= 32'd0;
        end else begin
            data_q     <= data_d;
            mask_q     <= mask_d;
            period_q   <= period_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign out_port = data_q ^ ({8{phase_q}} & mask_q);

endmodule

// File: tb/tb_uart_module_led.sv
// Directed testbench for uart_module_led. Expected values go into a
// scoreboard queue and are checked when the DUT output is sampled.
module tb_uart_module_led;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    typedef struct {
        string       tag;
        bit          is_rd;
        logic [31:0] exp;
    } sb_t;

    sb_t sb[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    uart_module_led dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input bit is_rd, input logic [31:0] exp);
        sb_t item;
        item.tag   = tag;
        item.is_rd = is_rd;
        item.exp   = exp;
        sb.push_back(item);
    endtask

    task automatic pop_chk();
        sb_t         item;
        logic [31:0] obs;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=none expected=entry");
        end else begin
            item = sb.pop_front();
            obs  = item.is_rd ? readdata : {24'd0, out_port};
            assert (obs === item.exp) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", item.tag, obs, item.exp);
            end
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] exp);
        push(tag, 1'b0, {24'd0, exp});
        pop_chk();
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
        address = a;
        push(tag, 1'b1, exp);
        tick();
        pop_chk();
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;

        // Reset state
        #2;
        chk_out("reset_out", 8'h00);
        push("reset_rd", 1'b1, 32'd0);
        pop_chk();
        #10 reset_n = 1'b1;
        tick();

        // Basic write
        wr(3'd0, 32'h0000_00A5);
        chk_out("basic_out", 8'hA5);
        rd("basic_rd", 3'd0, 32'h0000_00A5);

        // Set / clear
        wr(3'd0, 32'h0000_00F0);
        wr(3'd4, 32'h0000_000F);
        chk_out("outset", 8'hFF);
        wr(3'd5, 32'h0000_0081);
        chk_out("outclear", 8'h7E);
        rd("setclr_rd", 3'd0, 32'h0000_007E);

        // Blinking: data 0x00, mask 0x03, period 4
        wr(3'd0, 32'h0);
        wr(3'd1, 32'h3);
        chk_out("mask_no_blink", 8'h00);
        rd("mask_rd", 3'd1, 32'h3);
        wr(3'd2, 32'd4);
        address = 3'd3;
        for (int k = 0; k <= 13; k++) begin
            chk_out($sformatf("blink_out_k%0d", k), (((k / 4) % 2) == 1) ? 8'h03 : 8'h00);
            if (k >= 1) begin
                push($sformatf("blink_phase_k%0d", k), 1'b1, {31'd0, (((k - 1) / 4) % 2) == 1});
                pop_chk();
            end
            if (k < 13) tick();
        end

        // Disable while phase = 1
        wr(3'd2, 32'd0);
        chk_out("disable_out", 8'h00);
        rd("disable_phase", 3'd3, 32'd0);
        rd("disable_period", 3'd2, 32'd0);
        repeat (3) tick();
        chk_out("disabled_hold", 8'h00);

        // Ignored addresses
        wr(3'd3, 32'hFFFF_FFFF);
        wr(3'd6, 32'hFFFF_FFFF);
        wr(3'd7, 32'hFFFF_FFFF);
        rd("ign_data", 3'd0, 32'd0);
        rd("ign_mask", 3'd1, 32'd3);
        rd("ign_period", 3'd2, 32'd0);
        rd("ign_phase", 3'd3, 32'd0);
        rd("ign_rd6", 3'd6, 32'd0);
        chk_out("ign_out", 8'h00);

        // Period rewrite mid-count: period 10, rewrite to 3 at cnt = 7 with phase = 1
        wr(3'd2, 32'd10);
        repeat (9) tick();
        chk_out("p10_before_toggle", 8'h00);
        tick();
        chk_out("p10_toggle", 8'h03);
        repeat (7) tick();
        wr(3'd2, 32'd3);
        chk_out("rewrite_clear", 8'h00);
        tick();
        chk_out("rewrite_c1", 8'h00);
        tick();
        chk_out("rewrite_c2", 8'h00);
        tick();
        chk_out("rewrite_toggle", 8'h03);

        // Asynchronous reset between edges, mid-blink
        address = 3'd1;
        #3 reset_n = 1'b0;
        #1;
        chk_out("async_out", 8'h00);
        push("async_rd", 1'b1, 32'd0);
        pop_chk();
        #3 reset_n = 1'b1;
        tick();
        rd("post_data", 3'd0, 32'd0);
        rd("post_mask", 3'd1, 32'd0);
        rd("post_period", 3'd2, 32'd0);
        rd("post_phase", 3'd3, 32'd0);
        chk_out("post_out", 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
